// File: rtl/tx_iq_capture.sv
`timescale 1ns/1ps
// tx_iq_capture: non-intrusive capture buffer for the dot11_tx baseband IQ stream.
// Samples are stored linearly or in a ring, stopped by a trigger plus a post-trigger count.
module tx_iq_capture #(
    parameter int IQ_WIDTH   = 16,
    parameter int NUM_CH     = 1,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           arm,
    input  logic                           mode,
    input  logic [DEPTH_LOG2-1:0]          post_trig_len,
    input  logic                           trig,
    input  logic                           iq_valid,
    input  logic [NUM_CH*IQ_WIDTH-1:0]     iq_i,
    input  logic [NUM_CH*IQ_WIDTH-1:0]     iq_q,
    output logic                           iq_ready,
    input  logic [DEPTH_LOG2-1:0]          rd_addr,
    output logic [2*NUM_CH*IQ_WIDTH-1:0]   rd_data,
    output logic [1:0]                     state,
    output logic                           capture_done,
    output logic [DEPTH_LOG2:0]            wr_count,
    output logic                           wrapped,
    output logic [DEPTH_LOG2-1:0]          start_addr
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int WORD_W = 2 * NUM_CH * IQ_WIDTH;
    localparam logic [DEPTH_LOG2:0]   C_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   C_LAST    = C_FULL - 1'b1;
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_mode;
    logic [DEPTH_LOG2-1:0]  r_post_len;
    logic [DEPTH_LOG2-1:0]  r_post_cnt;
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2:0]    r_wr_count;
    logic                   r_wrapped;
    logic [DEPTH_LOG2-1:0]  r_start_addr;
    logic [WORD_W-1:0]      r_rd_data;
    logic [WORD_W-1:0]      r_mem [DEPTH];

    logic                   w_write;
    logic                   w_full_write;
    logic                   w_wrap_write;
    logic [DEPTH_LOG2-1:0]  w_wr_ptr_next;
    logic                   w_wrapped_next;
    logic                   w_enter_done;
    logic [WORD_W-1:0]      w_word;

    // An arm cycle never writes, so the new capture always starts at address 0.
    assign w_write      = iq_valid && !arm && (r_state == S_CAPTURE || r_state == S_POST);
    assign w_full_write = w_write && !r_mode && (r_wr_count == C_LAST);
    assign w_wrap_write = w_write && r_mode && (r_wr_ptr == {DEPTH_LOG2{1'b1}});

    assign w_wr_ptr_next  = w_write ? r_wr_ptr + C_PTR_ONE : r_wr_ptr;
    assign w_wrapped_next = r_wrapped || w_wrap_write;
    assign w_enter_done   = (w_state_next == S_DONE) && (r_state != S_DONE);

    always_comb begin
        w_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_word[c*2*IQ_WIDTH +: IQ_WIDTH]          = iq_i[c*IQ_WIDTH +: IQ_WIDTH];
            w_word[c*2*IQ_WIDTH + IQ_WIDTH +: IQ_WIDTH] = iq_q[c*IQ_WIDTH +: IQ_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Buffer-full in linear mode outranks the trigger; arm outranks everything.
    always_comb begin
        w_state_next = r_state;
        if (arm) begin
            w_state_next = S_CAPTURE;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    if (w_full_write) begin
                        w_state_next = S_DONE;
                    end else if (trig) begin
                        w_state_next = (r_post_len == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (w_write && (r_post_cnt == C_PTR_ONE || w_full_write)) begin
                        w_state_next = S_DONE;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode       <= 1'b0;
            r_post_len   <= '0;
            r_post_cnt   <= '0;
            r_wr_ptr     <= '0;
            r_wr_count   <= '0;
            r_wrapped    <= 1'b0;
            r_start_addr <= '0;
        end else if (arm) begin
            r_mode       <= mode;
            r_post_len   <= post_trig_len;
            r_post_cnt   <= '0;
            r_wr_ptr     <= '0;
            r_wr_count   <= '0;
            r_wrapped    <= 1'b0;
            r_start_addr <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_next;
            r_wrapped <= w_wrapped_next;
            if (w_write && r_wr_count != C_FULL) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            if (r_state == S_CAPTURE && trig) begin
                r_post_cnt <= r_post_len;
            end else if (r_state == S_POST && w_write) begin
                r_post_cnt <= r_post_cnt - C_PTR_ONE;
            end
            // After a wrap the oldest surviving sample sits at the next write slot.
            if (w_enter_done) begin
                r_start_addr <= w_wrapped_next ? w_wr_ptr_next : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign iq_ready     = 1'b1;
    assign rd_data      = r_rd_data;
    assign state        = r_state;
    assign capture_done = (r_state == S_DONE);
    assign wr_count     = r_wr_count;
    assign wrapped      = r_wrapped;
    assign start_addr   = r_start_addr;

endmodule

// File: tb/tb_tx_iq_capture.sv
`timescale 1ns/1ps
// tb_tx_iq_capture: directed and randomized stimulus against a sample-count based reference model.
// Two channels, 128-deep buffer so linear fill and ring wrap are reachable quickly.
module tb_tx_iq_capture;

    localparam int IQ_W = 16;
    localparam int NCH  = 2;
    localparam int DL   = 7;
    localparam int D    = 1 << DL;
    localparam int WW   = 2 * NCH * IQ_W;

    logic              clk = 1'b0;
    logic              rstn;
    logic              arm;
    logic              mode;
    logic [DL-1:0]     postTrigLen;
    logic              trig;
    logic              iqValid;
    logic [NCH*IQ_W-1:0] iqI;
    logic [NCH*IQ_W-1:0] iqQ;
    logic              iqReady;
    logic [DL-1:0]     rdAddr;
    logic [WW-1:0]     rdData;
    logic [1:0]        stateOut;
    logic              captureDone;
    logic [DL:0]       wrCount;
    logic              wrappedOut;
    logic [DL-1:0]     startAddr;

    int compared   = 0;
    int mismatched = 0;

    int            mState;
    int            mCount;
    int            mPost;
    int            mLen;
    bit            mMode;
    logic [WW-1:0] mMem [D];
    bit            mMemValid [D];
    logic [WW-1:0] rdExp;
    bit            rdKnown;

    tx_iq_capture #(.IQ_WIDTH(IQ_W), .NUM_CH(NCH), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rstn(rstn), .arm(arm), .mode(mode), .post_trig_len(postTrigLen),
        .trig(trig), .iq_valid(iqValid), .iq_i(iqI), .iq_q(iqQ), .iq_ready(iqReady),
        .rd_addr(rdAddr), .rd_data(rdData), .state(stateOut), .capture_done(captureDone),
        .wr_count(wrCount), .wrapped(wrappedOut), .start_addr(startAddr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DL-1:0] randAddr();
        return DL'($urandom);
    endfunction

    function automatic logic [31:0] rand32();
        return 32'($urandom);
    endfunction

    function automatic logic [WW-1:0] wordOf(input logic [31:0] i, input logic [31:0] q);
        return {q[31:16], i[31:16], q[15:0], i[15:0]};
    endfunction

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int expCount;
        bit expWrapped;
        expCount   = (mCount > D) ? D : mCount;
        expWrapped = mMode && (mCount >= D);
        check("state", WW'(stateOut), WW'(mState));
        check("capture_done", WW'(captureDone), WW'(mState == 3));
        check("wr_count", WW'(wrCount), WW'(expCount));
        check("wrapped", WW'(wrappedOut), WW'(expWrapped));
        check("iq_ready", WW'(iqReady), WW'(1));
        if (mState == 3) begin
            check("start_addr", WW'(startAddr), expWrapped ? WW'(mCount % D) : WW'(0));
        end
        if (rdKnown) begin
            check("rd_data", rdData, rdExp);
        end
    endtask

    // One clock of stimulus; the model then advances by the same cycle using sample counts.
    task automatic applyStimulus(input bit a, input bit m, input logic [DL-1:0] len, input bit t,
                                 input bit v, input logic [31:0] i, input logic [31:0] q,
                                 input logic [DL-1:0] ra);
        bit full;
        @(negedge clk);
        arm = a; mode = m; postTrigLen = len; trig = t; iqValid = v; iqI = i; iqQ = q; rdAddr = ra;
        @(posedge clk);
        #1;
        rdKnown = mMemValid[ra];
        rdExp   = mMem[ra];
        if (a) begin
            mState = 1; mCount = 0; mMode = m; mLen = int'(len);
        end else if (mState == 1 || mState == 2) begin
            if (v) begin
                mMem[mCount % D] = wordOf(i, q);
                mMemValid[mCount % D] = 1'b1;
                mCount++;
            end
            full = v && !mMode && (mCount == D);
            if (mState == 1) begin
                if (full) mState = 3;
                else if (t) begin
                    if (mLen == 0) mState = 3;
                    else begin mState = 2; mPost = mLen; end
                end
            end else if (v) begin
                mPost--;
                if (mPost == 0 || full) mState = 3;
            end
        end
        checkOutput();
    endtask

    task automatic doArm(input bit m, input logic [DL-1:0] len);
        applyStimulus(1'b1, m, len, 1'($urandom), 1'($urandom), rand32(), rand32(), randAddr());
    endtask

    task automatic doSample(input bit t, input bit v, input logic [31:0] i, input logic [31:0] q);
        applyStimulus(1'b0, 1'($urandom), randAddr(), t, v, i, q, randAddr());
    endtask

    task automatic doRead(input logic [DL-1:0] ra);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, rand32(), rand32(), ra);
    endtask

    initial begin
        logic [31:0]   ti;
        logic [31:0]   tq;
        logic [WW-1:0] saved;
        int            cycles;

        for (int k = 0; k < D; k++) begin
            mMemValid[k] = 1'b0;
            mMem[k] = '0;
        end
        mState = 0; mCount = 0; mPost = 0; mLen = 0; mMode = 1'b0;
        rdExp = '0; rdKnown = 1'b1;
        rstn = 1'b0; arm = 0; mode = 0; postTrigLen = '0; trig = 0; iqValid = 0;
        iqI = '0; iqQ = '0; rdAddr = '0;
        #3;
        checkOutput();
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] linear capture with post-trigger count");
        doArm(1'b0, 7'd10);
        for (int n = 0; n < 120; n++) begin
            ti = {16'($urandom), 16'(n)};
            tq = {16'($urandom), 16'(-n)};
            doSample(n == 99, 1'b1, ti, tq);
        end
        check("lin_state", WW'(stateOut), WW'(3));
        check("lin_count", WW'(wrCount), WW'(110));
        check("lin_start", WW'(startAddr), WW'(0));
        doRead(7'd99);
        check("lin_rd99", WW'(rdData[31:0]), WW'(32'hFF9D_0063));

        $display("[TB] linear fill without trigger");
        doArm(1'b0, 7'd50);
        saved = '0;
        for (int n = 0; n < 140; n++) begin
            ti = rand32(); tq = rand32();
            if (n == 0) saved = wordOf(ti, tq);
            doSample(1'b0, 1'b1, ti, tq);
        end
        check("fill_count", WW'(wrCount), WW'(D));
        doRead(7'd0);
        check("fill_rd0", rdData, saved);

        $display("[TB] ring capture with wrap");
        doArm(1'b1, 7'd4);
        for (int n = 1; n <= 150; n++) begin
            ti = rand32(); tq = rand32();
            if (n == 17) saved = wordOf(ti, tq);
            doSample(n == 140, 1'b1, ti, tq);
        end
        check("ring_wrapped", WW'(wrappedOut), WW'(1));
        check("ring_start", WW'(startAddr), WW'(16));
        doRead(7'd16);
        check("ring_oldest", rdData, saved);

        $display("[TB] zero post-trigger length");
        doArm(1'b0, 7'd0);
        for (int n = 1; n <= 5; n++) doSample(n == 5, 1'b1, rand32(), rand32());
        check("zero_state", WW'(stateOut), WW'(3));
        check("zero_count", WW'(wrCount), WW'(5));
        doSample(1'b1, 1'b1, rand32(), rand32());
        check("zero_retrig", WW'(wrCount), WW'(5));

        $display("[TB] asynchronous reset during post-trigger phase");
        doArm(1'b0, 7'd20);
        for (int n = 1; n <= 13; n++) doSample(n == 10, 1'b1, rand32(), rand32());
        check("post_state", WW'(stateOut), WW'(2));
        @(negedge clk);
        arm = 0; trig = 0; iqValid = 0;
        rstn = 1'b0;
        #1;
        check("rst_state", WW'(stateOut), WW'(0));
        check("rst_done", WW'(captureDone), WW'(0));
        check("rst_count", WW'(wrCount), WW'(0));
        check("rst_rd", rdData, '0);
        rstn = 1'b1;
        mState = 0; mCount = 0; rdExp = '0; rdKnown = 1'b1;
        doArm(1'b0, 7'd5);
        ti = rand32(); tq = rand32();
        doSample(1'b0, 1'b1, ti, tq);
        doRead(7'd0);
        check("rst_restart", rdData, wordOf(ti, tq));

        $display("[TB] two-channel packing and arm priority");
        doArm(1'b0, 7'd3);
        doSample(1'b0, 1'b1, {16'd3, 16'd1}, {16'd4, 16'd2});
        doRead(7'd0);
        check("pack", rdData, {16'd4, 16'd3, 16'd2, 16'd1});
        applyStimulus(1'b1, 1'b0, 7'd3, 1'b1, 1'b1, rand32(), rand32(), randAddr());
        check("armtrig_state", WW'(stateOut), WW'(1));
        check("armtrig_count", WW'(wrCount), WW'(0));
        for (int n = 0; n < 127; n++) doSample(1'b0, 1'b1, rand32(), rand32());
        applyStimulus(1'b1, 1'b0, 7'd9, 1'b0, 1'b1, rand32(), rand32(), randAddr());
        check("armfull_state", WW'(stateOut), WW'(1));
        check("armfull_count", WW'(wrCount), WW'(0));

        $display("[TB] randomized captures");
        for (int r = 0; r < 12; r++) begin
            doArm(1'($urandom), DL'($urandom_range(0, 40)));
            cycles = $urandom_range(60, 300);
            for (int c = 0; c < cycles; c++) begin
                if ($urandom_range(0, 199) == 0) begin
                    doArm(1'($urandom), DL'($urandom_range(0, 40)));
                end else begin
                    doSample($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, rand32(), rand32());
                end
            end
        end
        for (int a = 0; a < D; a++) doRead(DL'(a));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
